toi2s_i2s_tx: RTL and testbench

//  Stereo I2S transmitter feeding the amplifier pins amp_i2s_bck/ws/d0 of toi2s_tt_top.

---
 rtl/toi2s_i2s_tx.sv | 166 ++++++++++++++++
 tb/tb_toi2s_i2s_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toi2s_i2s_tx.sv
// Stereo Philips-I2S master transmitter: 2-entry pair FIFO, bck/ws generation, MSB-first serialiser.
// Build option: define I2S_TX_HOLD_LAST_EN to repeat the last popped pair on underrun instead of zeros.
module toi2s_i2s_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                ena,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                i2s_bck,
  output logic                i2s_ws,
  output logic                i2s_d0,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int PAD_W   = SLOT_W - SAMPLE_W;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] ws_idx;
  logic             ws_nxt;
  logic             div_tc;
  logic             fall_evt;
  logic             wrap;

  logic [FRAME_W-1:0] frame_sr;

  pair_t      fifo_mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  pair_t      head;
  pair_t      fill_pair;
  pair_t      load_pair;

  assign div_tc   = (div_cnt == DIV_W'(BCK_DIV - 1));
  assign fall_evt = div_tc & i2s_bck;
  assign wrap     = fall_evt & (bit_cnt == BIT_W'(FRAME_W - 1));

  // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    bit_nxt = (bit_cnt == BIT_W'(FRAME_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
    ws_idx  = (bit_nxt == BIT_W'(FRAME_W - 1)) ? '0 : bit_nxt + BIT_W'(1);
    ws_nxt  = (ws_idx >= BIT_W'(SLOT_W));
  end

  // FIFO control; s_ready looks only at the registered full flag.
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign s_ready = ena & ~full;
  assign push    = s_valid & s_ready;
  assign pop     = wrap & ~empty;
  assign head    = fifo_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (!ena) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written, guarded by count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{left: s_left, right: s_right};
  end

`ifdef I2S_TX_HOLD_LAST_EN
  pair_t hold_pair;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_pair <= '0;
    end else if (!ena) begin
      hold_pair <= '0;
    end else if (pop) begin
      hold_pair <= head;
    end
  end

  assign fill_pair = hold_pair;
`else
  assign fill_pair = '0;
`endif

  assign load_pair = empty ? fill_pair : head;

  // Clock generation and serialiser; every frame-level update happens on a bck fall event.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      frame_sr    <= '0;
      i2s_bck     <= 1'b0;
      i2s_ws      <= 1'b0;
      i2s_d0      <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else if (!ena) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      frame_sr    <= '0;
      i2s_bck     <= 1'b0;
      i2s_ws      <= 1'b0;
      i2s_d0      <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (div_tc) begin
        div_cnt <= '0;
        i2s_bck <= ~i2s_bck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        i2s_ws  <= ws_nxt;
        if (wrap) begin
          // Slot layout: sample MSB-aligned, zero padded; shifted out from bit 1 of the frame.
          frame_sr    <= {load_pair.left, {PAD_W{1'b0}}, load_pair.right, {PAD_W{1'b0}}};
          i2s_d0      <= 1'b0;
          frame_start <= 1'b1;
          underrun    <= empty;
        end else begin
          i2s_d0   <= frame_sr[FRAME_W-1];
          frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_toi2s_i2s_tx.sv
// Directed bench for toi2s_i2s_tx (SAMPLE_W=16, SLOT_W=32, BCK_DIV=2): frames are captured bit by
// bit on bck falling edges and compared against hand-derived I2S frame images.
module tb_toi2s_i2s_tx;

  logic        clk = 1'b0;
  logic        resetb;
  logic        ena;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic        i2s_bck;
  logic        i2s_ws;
  logic        i2s_d0;
  logic        frame_start;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  toi2s_i2s_tx #(
    .SAMPLE_W(16),
    .SLOT_W  (32),
    .BCK_DIV (2)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .ena        (ena),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .i2s_bck    (i2s_bck),
    .i2s_ws     (i2s_ws),
    .i2s_d0     (i2s_d0),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  // Frame image indexed by k = bit position after the fall event.
  function automatic logic [63:0] exp_data(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    v = '0;
    for (int k = 1; k <= 16; k++) v[k] = l[16-k];
    for (int k = 33; k <= 48; k++) v[k] = r[48-k];
    return v;
  endfunction

  function automatic logic [63:0] exp_ws();
    logic [63:0] v;
    v = '0;
    for (int k = 31; k <= 62; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic next_fall(output logic ok);
    int n;
    n = 0;
    while (i2s_bck !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    while (i2s_bck !== 1'b0 && n < 16) begin @(negedge clk); n++; end
    if (n == 0) begin
      @(negedge clk);
      while (i2s_bck !== 1'b1 && n < 16) begin @(negedge clk); n++; end
      while (i2s_bck !== 1'b0 && n < 16) begin @(negedge clk); n++; end
    end
    ok = (n < 16);
    if (!ok) begin
      total++; bad++;
      $display("FAIL bck_fall_timeout: bck=%b, no falling edge within 16 clk", i2s_bck);
    end
  endtask

  task automatic wait_falls(input int n);
    logic ok;
    for (int i = 0; i < n; i++) begin
      next_fall(ok);
      if (!ok) return;
    end
  endtask

  task automatic wait_frame_start(output logic urun, output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    ok   = (frame_start === 1'b1);
    urun = underrun;
    if (!ok) begin
      total++; bad++;
      $display("FAIL frame_start_timeout: no frame_start within 600 clk");
    end
  endtask

  task automatic capture_frame(output logic [63:0] d, output logic [63:0] w, output logic urun);
    logic ok;
    d = 'x;
    w = 'x;
    wait_frame_start(urun, ok);
    if (!ok) return;
    d[0] = i2s_d0;
    w[0] = i2s_ws;
    for (int k = 1; k < 64; k++) begin
      next_fall(ok);
      if (!ok) return;
      d[k] = i2s_d0;
      w[k] = i2s_ws;
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r, output int waited);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    waited  = 0;
    while (s_ready !== 1'b1 && waited < 1000) begin @(negedge clk); waited++; end
    if (s_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL push_timeout: s_ready=%b after %0d clk", s_ready, waited);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_left  = ~l;
    s_right = ~r;
  endtask

  // Counts bck falls until frame_start is seen; returns count and underrun at that point.
  task automatic falls_to_frame(output int n, output logic urun);
    logic ok;
    n = 0;
    ok = 1'b1;
    do begin
      next_fall(ok);
      n++;
    end while (frame_start !== 1'b1 && n < 100 && ok);
    urun = underrun;
  endtask

  task automatic test_reset();
    resetb = 1'b0; ena = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({i2s_bck, i2s_ws, i2s_d0, frame_start, underrun, s_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: bck/ws/d0/fs/ur/rdy=%b expected 000000",
               {i2s_bck, i2s_ws, i2s_d0, frame_start, underrun, s_ready});
    end
    resetb = 1'b1;
    ena    = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_enable: s_ready=%b expected 1", s_ready);
    end
  endtask

  task automatic test_single_pair();
    logic [63:0] d, w;
    logic        u;
    int          wt;
    push_pair(16'hA5C3, 16'h0F0F, wt);
    capture_frame(d, w, u);
    total++;
    if (d !== exp_data(16'hA5C3, 16'h0F0F)) begin
      bad++; $display("FAIL single_data: got=%h expected=%h", d, exp_data(16'hA5C3, 16'h0F0F));
    end
    total++;
    if (w !== exp_ws()) begin
      bad++; $display("FAIL single_ws: got=%h expected=%h", w, exp_ws());
    end
    total++;
    if (u !== 1'b0) begin
      bad++; $display("FAIL single_underrun: got=%b expected 0", u);
    end
  endtask

  task automatic test_underrun();
    logic [63:0] d, w, e;
    logic        u;
`ifdef I2S_TX_HOLD_LAST_EN
    e = exp_data(16'hA5C3, 16'h0F0F);
`else
    e = '0;
`endif
    capture_frame(d, w, u);
    total++;
    if (u !== 1'b1) begin
      bad++; $display("FAIL underrun_pulse: got=%b expected 1", u);
    end
    total++;
    if (d !== e) begin
      bad++; $display("FAIL underrun_data: got=%h expected=%h", d, e);
    end
    total++;
    if (w !== exp_ws()) begin
      bad++; $display("FAIL underrun_ws: got=%h expected=%h", w, exp_ws());
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1, d2, d3, w1, w2, w3;
    logic        u0, u1, u2, u3, ok;
    int          wt1, wt2, wt3;
    wait_frame_start(u0, ok);
    push_pair(16'h1234, 16'h8765, wt1);
    push_pair(16'h8001, 16'h7FFE, wt2);
    total++;
    if (s_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_ready_full: s_ready=%b expected 0", s_ready);
    end
    fork
      push_pair(16'hFFFF, 16'h0001, wt3);
      capture_frame(d1, w1, u1);
    join
    total++;
    if (wt3 < 100) begin
      bad++; $display("FAIL b2b_third_stall: waited=%0d clk expected >=100", wt3);
    end
    capture_frame(d2, w2, u2);
    capture_frame(d3, w3, u3);
    total++;
    if (d1 !== exp_data(16'h1234, 16'h8765)) begin
      bad++; $display("FAIL b2b_frame1: got=%h expected=%h", d1, exp_data(16'h1234, 16'h8765));
    end
    total++;
    if (d2 !== exp_data(16'h8001, 16'h7FFE)) begin
      bad++; $display("FAIL b2b_frame2: got=%h expected=%h", d2, exp_data(16'h8001, 16'h7FFE));
    end
    total++;
    if (d3 !== exp_data(16'hFFFF, 16'h0001)) begin
      bad++; $display("FAIL b2b_frame3: got=%h expected=%h", d3, exp_data(16'hFFFF, 16'h0001));
    end
    total++;
    if ({u1, u2, u3} !== 3'b000) begin
      bad++; $display("FAIL b2b_underrun: got=%b expected 000", {u1, u2, u3});
    end
    total++;
    if (w3 !== exp_ws()) begin
      bad++; $display("FAIL b2b_ws: got=%h expected=%h", w3, exp_ws());
    end
  endtask

  task automatic test_push_pop();
    logic [63:0] d4, d5, dx, w;
    logic        u0, u4, u5, ux, ok;
    int          wt;
    wait_frame_start(u0, ok);
    push_pair(16'h3C3C, 16'hC3C3, wt);
    wait_falls(63);
    repeat (3) @(posedge clk);
    #1;
    s_left  = 16'h5A5A;
    s_right = 16'h6B6B;
    s_valid = 1'b1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++; $display("FAIL pp_ready: s_ready=%b expected 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    total++;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL pp_coincident_pop: frame_start=%b expected 1", frame_start);
    end
    capture_frame(d4, w, u4);
    capture_frame(d5, w, u5);
    capture_frame(dx, w, ux);
    total++;
    if (d4 !== exp_data(16'h3C3C, 16'hC3C3)) begin
      bad++; $display("FAIL pp_first: got=%h expected=%h", d4, exp_data(16'h3C3C, 16'hC3C3));
    end
    total++;
    if (d5 !== exp_data(16'h5A5A, 16'h6B6B)) begin
      bad++; $display("FAIL pp_second: got=%h expected=%h", d5, exp_data(16'h5A5A, 16'h6B6B));
    end
    total++;
    if ({u4, u5, ux} !== 3'b001) begin
      bad++; $display("FAIL pp_underrun_seq: got=%b expected 001", {u4, u5, ux});
    end
  endtask

  task automatic test_ena_drop();
    logic u0, u, ok;
    int   wt, n;
    wait_frame_start(u0, ok);
    push_pair(16'h1111, 16'h2222, wt);
    push_pair(16'h3333, 16'h4444, wt);
    wait_falls(20);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({i2s_bck, i2s_ws, i2s_d0, s_ready, frame_start, underrun} !== 6'b0) begin
        bad++;
        $display("FAIL ena_low_hold cycle %0d: bck/ws/d0/rdy/fs/ur=%b expected 000000", i,
                 {i2s_bck, i2s_ws, i2s_d0, s_ready, frame_start, underrun});
      end
    end
    ena = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++; $display("FAIL ena_fifo_flushed: s_ready=%b expected 1", s_ready);
    end
    falls_to_frame(n, u);
    total++;
    if (n !== 64) begin
      bad++; $display("FAIL ena_first_pop: falls=%0d expected 64", n);
    end
    total++;
    if (u !== 1'b1) begin
      bad++; $display("FAIL ena_pop_underrun: got=%b expected 1", u);
    end
  endtask

  task automatic test_async_reset();
    logic u0, u, ok;
    int   wt, n;
    push_pair(16'h0000, 16'h0100, wt);
    wait_frame_start(u0, ok);
    total++;
    if (u0 !== 1'b0) begin
      bad++; $display("FAIL rst_pre_underrun: got=%b expected 0", u0);
    end
    wait_falls(40);
    total++;
    if ({i2s_ws, i2s_d0} !== 2'b11) begin
      bad++; $display("FAIL rst_pre_state: ws/d0=%b expected 11", {i2s_ws, i2s_d0});
    end
    #2;
    resetb = 1'b0;
    #1;
    total++;
    if ({i2s_bck, i2s_ws, i2s_d0, frame_start, underrun} !== 5'b0) begin
      bad++;
      $display("FAIL rst_async: bck/ws/d0/fs/ur=%b expected 00000",
               {i2s_bck, i2s_ws, i2s_d0, frame_start, underrun});
    end
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    falls_to_frame(n, u);
    total++;
    if (n !== 64) begin
      bad++; $display("FAIL rst_restart: falls=%0d expected 64", n);
    end
    total++;
    if (u !== 1'b1) begin
      bad++; $display("FAIL rst_no_resume: underrun=%b expected 1", u);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_underrun();
    test_back_to_back();
    test_push_pop();
    test_ena_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
